// File: rtl/mmio_port_bank_pkg.sv
// Shared constants for the memory-mapped GPIO bank: window base and per-port register offsets.
package mmio_port_bank_pkg;

  // Default base of the GPIO window in the 10-bit data address space.
  localparam logic [9:0] MMIO_BASE_ADDR = 10'h3C0;

  // Register offsets within one 4-address port slot.
  typedef enum logic [1:0] {
    OFF_OUT  = 2'd0,
    OFF_IN   = 2'd1,
    OFF_FLAG = 2'd2,
    OFF_MASK = 2'd3
  } mmio_off_e;

endpackage

// File: rtl/mmio_port_bank_io_sync_edge.sv
// Two-flop input synchroniser with rising-edge detect against a previous-value flop.
module io_sync_edge #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  output logic [W-1:0] sync,
  output logic [W-1:0] rise
);

  logic [W-1:0] s1_q, s2_q, prv_q;

  // Synchroniser chain plus previous-value flop; reset drops any edge in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q  <= '0;
      s2_q  <= '0;
      prv_q <= '0;
    end else begin
      s1_q  <= din;
      s2_q  <= s1_q;
      prv_q <= s2_q;
    end
  end

  assign sync = s2_q;
  assign rise = s2_q & ~prv_q;

endmodule

// File: rtl/mmio_port_bank.sv
// Memory-mapped GPIO bank: address decode, OUT/FLAG/MASK registers, read mux and interrupt.
module mmio_port_bank
  import mmio_port_bank_pkg::*;
#(
  parameter int unsigned       DATA_W    = 8,
  parameter int unsigned       ADDR_W    = 10,
  parameter int unsigned       NUM_PORTS = 4,
  parameter int unsigned       PORT_W    = 4,
  parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(MMIO_BASE_ADDR)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [ADDR_W-1:0]           addr,
  input  logic                        w_en,
  input  logic [DATA_W-1:0]           d_in,
  output logic [DATA_W-1:0]           d_out,
  output logic                        hit,
  input  logic [NUM_PORTS*PORT_W-1:0] io_in,
  output logic [NUM_PORTS*PORT_W-1:0] io_out,
  output logic                        irq
);

  logic [NUM_PORTS-1:0][PORT_W-1:0] out_q, out_d;
  logic [NUM_PORTS-1:0][PORT_W-1:0] flag_q, flag_d;
  logic [NUM_PORTS-1:0][PORT_W-1:0] mask_q, mask_d;
  logic [NUM_PORTS-1:0][PORT_W-1:0] sync, rise;
  logic                             irq_q, irq_d;

  logic [ADDR_W:0]       addr_ext, win_lo, win_hi;
  logic [ADDR_W-1:0]     rel_port;
  logic [NUM_PORTS-1:0]  port_sel;
  mmio_off_e             offset;
  logic [PORT_W-1:0]     wdata, rdata;
  logic                  unused_d_in;

  // Only the low PORT_W bits of the write data are meaningful.
  assign wdata       = d_in[PORT_W-1:0];
  assign unused_d_in = ^d_in;

  // One synchroniser/edge detector per port.
  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port_sync
    io_sync_edge #(
      .W (PORT_W)
    ) u_sync (
      .clk  (clk),
      .rst  (rst),
      .din  (io_in[p*PORT_W +: PORT_W]),
      .sync (sync[p]),
      .rise (rise[p])
    );
  end

  // Window decode; one extra bit keeps the upper bound from wrapping at the top of memory.
  always_comb begin
    addr_ext = {1'b0, addr};
    win_lo   = {1'b0, BASE_ADDR};
    win_hi   = win_lo + (ADDR_W + 1)'(4 * NUM_PORTS);
    hit      = (addr_ext >= win_lo) && (addr_ext < win_hi);
    rel_port = (addr - BASE_ADDR) >> 2;
    offset   = mmio_off_e'(addr[1:0]);
    port_sel = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      port_sel[p] = hit && (rel_port == ADDR_W'(p));
    end
  end

  // Register next-state: writes to the selected port, sticky rise flags with set beating clear.
  always_comb begin
    out_d  = out_q;
    mask_d = mask_q;
    for (int p = 0; p < NUM_PORTS; p++) begin
      flag_d[p] = flag_q[p] | rise[p];
      if (w_en && port_sel[p]) begin
        unique case (offset)
          OFF_OUT:  out_d[p]  = wdata;
          OFF_IN:   ;
          OFF_FLAG: flag_d[p] = (flag_q[p] & ~wdata) | rise[p];
          OFF_MASK: mask_d[p] = wdata;
          default:  ;
        endcase
      end
    end
    irq_d = |(flag_q & mask_q);
  end

  // Read mux; zero outside the window.
  always_comb begin
    rdata = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (port_sel[p]) begin
        unique case (offset)
          OFF_OUT:  rdata = out_q[p];
          OFF_IN:   rdata = sync[p];
          OFF_FLAG: rdata = flag_q[p];
          OFF_MASK: rdata = mask_q[p];
          default:  rdata = '0;
        endcase
      end
    end
    d_out = DATA_W'(rdata);
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q  <= '0;
      flag_q <= '0;
      mask_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      out_q  <= out_d;
      flag_q <= flag_d;
      mask_q <= mask_d;
      irq_q  <= irq_d;
    end
  end

  assign io_out = out_q;
  assign irq    = irq_q;

endmodule

// File: tb/tb_mmio_port_bank.sv
// Directed bench for mmio_port_bank with immediate-assertion checks.
module tb_mmio_port_bank;

  localparam logic [9:0] BASE = 10'h3C0;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  addr;
  logic        w_en;
  logic [7:0]  d_in;
  logic [7:0]  d_out;
  logic        hit;
  logic [15:0] io_in;
  logic [15:0] io_out;
  logic        irq;

  int n_checks = 0;
  int n_fail   = 0;

  mmio_port_bank dut (
    .clk    (clk),
    .rst    (rst),
    .addr   (addr),
    .w_en   (w_en),
    .d_in   (d_in),
    .d_out  (d_out),
    .hit    (hit),
    .io_in  (io_in),
    .io_out (io_out),
    .irq    (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [9:0] a, input logic [7:0] d);
    addr = a;
    d_in = d;
    w_en = 1'b1;
    @(posedge clk);
    #1;
    w_en = 1'b0;
  endtask

  task automatic rd(input logic [9:0] a, input logic [31:0] exp, input string tag);
    addr = a;
    w_en = 1'b0;
    #1;
    check(tag, 32'(d_out), exp);
  endtask

  initial begin
    rst   = 1'b1;
    addr  = '0;
    w_en  = 1'b0;
    d_in  = '0;
    io_in = '0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check("reset_io_out", 32'(io_out), 32'h0);
    check("reset_irq", 32'(irq), 32'h0);
    rd(BASE + 10'd0, 32'h0, "reset_out0");
    rd(BASE + 10'd2, 32'h0, "reset_flag0");

    // Output registers
    wr(BASE + 10'd0, 8'h0A);
    check("io_out_p0", 32'(io_out[3:0]), 32'hA);
    wr(BASE + 10'd4, 8'h05);
    check("io_out_p1", 32'(io_out[7:4]), 32'h5);
    rd(BASE + 10'd0, 32'h0A, "rd_out0");
    check("hit_in_window", 32'(hit), 32'h1);
    rd(BASE + 10'd4, 32'h05, "rd_out1");
    wr(BASE + 10'd1, 8'hFF);
    check("in_write_ignored", 32'(io_out), 32'h005A);
    rd(BASE + 10'd1, 32'h0, "rd_in0_idle");

    // Input sync and flag timing: pins rise before edge k
    io_in = 16'h0003;
    tick();                                   // edge k
    rd(BASE + 10'd1, 32'h0, "in_after_k");
    tick();                                   // edge k+1
    rd(BASE + 10'd1, 32'h3, "in_after_k1");
    rd(BASE + 10'd2, 32'h0, "flag_after_k1");
    tick();                                   // edge k+2
    rd(BASE + 10'd2, 32'h3, "flag_after_k2");
    check("irq_unmasked", 32'(irq), 32'h0);
    io_in = 16'h0000;
    tick();
    tick();
    tick();
    rd(BASE + 10'd2, 32'h3, "flag_sticky");
    rd(BASE + 10'd1, 32'h0, "in_fell");
    check("irq_still_0", 32'(irq), 32'h0);

    // Mask and W1C
    wr(BASE + 10'd3, 8'h01);
    check("irq_mask_lag", 32'(irq), 32'h0);
    tick();
    check("irq_masked", 32'(irq), 32'h1);
    wr(BASE + 10'd2, 8'h01);
    rd(BASE + 10'd2, 32'h2, "flag_w1c");
    check("irq_clear_lag", 32'(irq), 32'h1);
    tick();
    check("irq_cleared", 32'(irq), 32'h0);

    // Rise coincident with W1C of the same bit: set wins
    io_in = 16'h0001;
    tick();                                   // edge k
    tick();                                   // edge k+1, rise active
    wr(BASE + 10'd2, 8'h01);                  // edge k+2
    rd(BASE + 10'd2, 32'h3, "flag_set_wins");
    tick();
    check("irq_after_set_wins", 32'(irq), 32'h1);

    // Out-of-window accesses
    addr = BASE - 10'd1;
    d_in = 8'hFF;
    w_en = 1'b1;
    #1;
    check("hit_below", 32'(hit), 32'h0);
    check("dout_below", 32'(d_out), 32'h0);
    tick();
    addr = BASE + 10'd16;
    #1;
    check("hit_above", 32'(hit), 32'h0);
    check("dout_above", 32'(d_out), 32'h0);
    tick();
    w_en = 1'b0;
    check("io_out_unchanged", 32'(io_out), 32'h005A);
    rd(BASE + 10'd3, 32'h1, "mask0_unchanged");
    rd(BASE + 10'd15, 32'h0, "mask3_idle");
    check("hit_top", 32'(hit), 32'h1);
    wr(BASE + 10'd15, 8'h0C);
    rd(BASE + 10'd15, 32'hC, "mask3_written");

    // Reset mid-operation with an edge in flight
    check("irq_before_reset", 32'(irq), 32'h1);
    rst   = 1'b1;
    io_in = 16'h0011;
    tick();
    check("rst_io_out", 32'(io_out), 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    rd(BASE + 10'd0, 32'h0, "rst_out0");
    rd(BASE + 10'd2, 32'h0, "rst_flag0");
    rd(BASE + 10'd3, 32'h0, "rst_mask0");
    tick();
    io_in = 16'h0000;
    rst   = 1'b0;
    tick();
    tick();
    tick();
    tick();
    rd(BASE + 10'd2, 32'h0, "no_flag_p0");
    rd(BASE + 10'd6, 32'h0, "no_flag_p1");
    check("irq_after_reset", 32'(irq), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
